// File: rtl/hazard_pkg.sv
// Shared encodings and default latencies for the decode-stage hazard scoreboard.
package hazard_pkg;

    typedef enum logic [1:0] {
        CAUSE_NONE   = 2'd0,
        CAUSE_RAW    = 2'd1,
        CAUSE_STRUCT = 2'd2,
        CAUSE_WAW    = 2'd3
    } cause_e;

    localparam int DEF_NUM_REGS = 8;
    localparam int DEF_REG_W    = 3;
    localparam int DEF_LAT_W    = 3;
    localparam int DEF_ALU_LAT  = 0;
    localparam int DEF_LOAD_LAT = 1;
    localparam int DEF_CNT_W    = 16;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-side instruction description in, front-end stall controls out.
interface hazard_scoreboard_if #(
    parameter int REG_W = hazard_pkg::DEF_REG_W,
    parameter int LAT_W = hazard_pkg::DEF_LAT_W,
    parameter int CNT_W = hazard_pkg::DEF_CNT_W
);
    logic                  id_valid;
    logic [REG_W-1:0]      id_rs;
    logic                  id_rs_used;
    logic [REG_W-1:0]      id_rt;
    logic                  id_rt_used;
    logic [REG_W-1:0]      id_dst;
    logic                  id_dst_we;
    logic                  id_is_load;
    logic                  id_is_mc;
    logic [LAT_W-1:0]      id_mc_lat;
    logic                  flush;
    logic                  stall;
    logic                  pc_we;
    logic                  ifid_we;
    logic                  idex_bubble;
    hazard_pkg::cause_e    stall_cause;
    logic [CNT_W-1:0]      stall_count;

    modport master (
        output id_valid, id_rs, id_rs_used, id_rt, id_rt_used, id_dst, id_dst_we,
               id_is_load, id_is_mc, id_mc_lat, flush,
        input  stall, pc_we, ifid_we, idex_bubble, stall_cause, stall_count
    );

    modport slave (
        input  id_valid, id_rs, id_rs_used, id_rt, id_rt_used, id_dst, id_dst_we,
               id_is_load, id_is_mc, id_mc_lat, flush,
        output stall, pc_we, ifid_we, idex_bubble, stall_cause, stall_count
    );
endinterface

// File: rtl/sb_counter.sv
// Saturating-at-zero down-counter with synchronous load; load wins over the decrement.
module sb_counter #(
    parameter int LAT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_i,
    input  logic [LAT_W-1:0] ld_val_i,
    output logic [LAT_W-1:0] cnt_o
);
    logic [LAT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (ld_i)
            cnt_d = ld_val_i;
        else if (cnt_q != '0)
            cnt_d = cnt_q - LAT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard: raises RAW/structural/WAW stalls for the decode stage.
// Combinational stall from current state; counters and stall_count update every clock.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int REG_W    = DEF_REG_W,
    parameter int LAT_W    = DEF_LAT_W,
    parameter int ALU_LAT  = DEF_ALU_LAT,
    parameter int LOAD_LAT = DEF_LOAD_LAT,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    hazard_scoreboard_if.slave hz
);
    logic [LAT_W-1:0] reg_cnt [NUM_REGS];
    logic [LAT_W-1:0] mc_busy;
    logic [LAT_W-1:0] lat;
    logic             live, raw, strc, waw, stall, issue;
    cause_e           cause;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    always_comb begin
        lat = LAT_W'(ALU_LAT);
        if (hz.id_is_mc)
            lat = hz.id_mc_lat;
        else if (hz.id_is_load)
            lat = LAT_W'(LOAD_LAT);
    end

    // Only state left by older, already-issued ops is examined, so rs==dst is never a self-hazard.
    assign live  = hz.id_valid & ~hz.flush;
    assign raw   = live & ((hz.id_rs_used & (reg_cnt[hz.id_rs] != '0)) |
                           (hz.id_rt_used & (reg_cnt[hz.id_rt] != '0)));
    assign strc  = live & hz.id_is_mc & (mc_busy != '0);
    assign waw   = live & hz.id_dst_we & (reg_cnt[hz.id_dst] > lat);
    assign stall = raw | strc | waw;
    assign issue = live & ~stall;

    always_comb begin
        cause = CAUSE_NONE;
        if (raw)       cause = CAUSE_RAW;
        else if (strc) cause = CAUSE_STRUCT;
        else if (waw)  cause = CAUSE_WAW;
    end

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
        sb_counter #(.LAT_W(LAT_W)) u_cnt (
            .clk      (clk),
            .rst      (rst),
            .ld_i     (issue & hz.id_dst_we & (hz.id_dst == REG_W'(r))),
            .ld_val_i (lat),
            .cnt_o    (reg_cnt[r])
        );
    end

    sb_counter #(.LAT_W(LAT_W)) u_mc_busy (
        .clk      (clk),
        .rst      (rst),
        .ld_i     (issue & hz.id_is_mc),
        .ld_val_i (hz.id_mc_lat),
        .cnt_o    (mc_busy)
    );

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != '1))
            stall_count_d = stall_count_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) stall_count_q <= '0;
        else     stall_count_q <= stall_count_d;
    end

    assign hz.stall       = stall;
    assign hz.pc_we       = ~stall;
    assign hz.ifid_we     = ~stall;
    assign hz.idex_bubble = stall | hz.flush | ~hz.id_valid;
    assign hz.stall_cause = cause;
    assign hz.stall_count = stall_count_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (CNT_W=4 build so saturation is reachable).
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.REG_W(3), .LAT_W(3), .CNT_W(4)) hz ();

    hazard_scoreboard #(.NUM_REGS(8), .REG_W(3), .LAT_W(3), .ALU_LAT(0), .LOAD_LAT(1), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    typedef struct {
        string      nm;
        logic [5:0] v;     // {stall, pc_we, ifid_we, bubble, cause}
        bit         cc;
        logic [3:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [5:0] act;
            e   = exp_q.pop_front();
            act = {hz.stall, hz.pc_we, hz.ifid_we, hz.idex_bubble, 2'(hz.stall_cause)};
            total++;
            if (act !== e.v || (e.cc && hz.stall_count !== e.cnt)) begin
                bad++;
                $display("FAIL %s: got st/pc/ifid/bub/cause=%b count=%0d, want %b count=%0d",
                         e.nm, act, hz.stall_count, e.v, e.cnt);
            end
        end
    end

    task automatic drive(bit v, int rs, bit rsu, int rt, bit rtu, int dst, bit we,
                         bit ld, bit mc, int mlat);
        hz.id_valid   = v;
        hz.id_rs      = 3'(rs);
        hz.id_rs_used = rsu;
        hz.id_rt      = 3'(rt);
        hz.id_rt_used = rtu;
        hz.id_dst     = 3'(dst);
        hz.id_dst_we  = we;
        hz.id_is_load = ld;
        hz.id_is_mc   = mc;
        hz.id_mc_lat  = 3'(mlat);
        hz.flush      = 1'b0;
    endtask

    task automatic nop();                     drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic alu(int rs, int rt, int d); drive(1, rs, 1, rt, 1, d, 1, 0, 0, 0); endtask
    task automatic rd(int rs);                drive(1, rs, 1, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic load(int d);               drive(1, 0, 0, 0, 0, d, 1, 1, 0, 0); endtask
    task automatic mcop(int rs, bit rsu, int d, int l); drive(1, rs, rsu, 0, 0, d, 1, 0, 1, l); endtask

    // Push this cycle's expectation (bubble/pc_we derived from the intended stall), then advance.
    task automatic cyc(string nm, bit chk, bit es, int ec, bit cc, int ecnt);
        if (chk) begin
            exp_t e;
            logic bub;
            bub   = es | hz.flush | ~hz.id_valid;
            e.nm  = nm;
            e.v   = {es, ~es, ~es, bub, 2'(ec)};
            e.cc  = cc;
            e.cnt = 4'(ecnt);
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        nop();
        cyc("rst_a", 0, 0, 0, 0, 0);
        cyc("rst_b", 1, 0, 0, 1, 0);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        nop();
        @(posedge clk);
        #1;

        // Reset with a valid instruction present, then every register reads as free.
        rst = 1'b1;
        alu(3, 5, 2);
        cyc("reset_1", 0, 0, 0, 0, 0);
        cyc("reset_2", 1, 0, 0, 1, 0);
        rst = 1'b0;
        for (int r = 0; r < 8; r++) begin
            drive(1, r, 1, 7 - r, 1, 0, 0, 0, 0, 0);
            cyc("clear_regs", 1, 0, 0, 1, 0);
        end

        // Load-use: exactly one bubble.
        do_reset();
        load(3);        cyc("lu_load",  1, 0, 0, 1, 0);
        alu(3, 1, 6);   cyc("lu_stall", 1, 1, 1, 1, 0);
        alu(3, 1, 6);   cyc("lu_issue", 1, 0, 0, 1, 1);
        nop();          cyc("lu_idle",  1, 0, 0, 1, 1);

        // Multi-cycle RAW, latency 4.
        do_reset();
        mcop(0, 0, 5, 4); cyc("mc_issue", 1, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            alu(5, 0, 6); cyc("mc_raw", 1, 1, 1, 0, 0);
        end
        alu(5, 0, 6);     cyc("mc_raw_go", 1, 0, 0, 1, 4);

        // Independent ALU op behind a multi-cycle op.
        do_reset();
        mcop(0, 0, 5, 4); cyc("ind_mc", 1, 0, 0, 0, 0);
        alu(2, 2, 6);     cyc("ind_alu", 1, 0, 0, 1, 0);

        // Structural: second mc op waits out the busy unit.
        do_reset();
        mcop(0, 0, 1, 5); cyc("st_first", 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            mcop(0, 1, 2, 3); cyc("st_stall", 1, 1, 2, 0, 0);
        end
        mcop(0, 1, 2, 3); cyc("st_go", 1, 0, 0, 1, 5);

        // WAW: ALU write to r1 waits until the mc result lands.
        do_reset();
        mcop(0, 0, 1, 5); cyc("waw_mc", 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 0, 0, 0, 1, 1, 0, 0, 0); cyc("waw_stall", 1, 1, 3, 0, 0);
        end
        drive(1, 0, 0, 0, 0, 1, 1, 0, 0, 0); cyc("waw_go", 1, 0, 0, 1, 5);
        rd(1);            cyc("waw_after", 1, 0, 0, 1, 5);

        // RAW outranks structural.
        do_reset();
        mcop(0, 0, 1, 2); cyc("pri_mc", 1, 0, 0, 0, 0);
        mcop(1, 1, 3, 1); cyc("pri_raw1", 1, 1, 1, 0, 0);
        mcop(1, 1, 3, 1); cyc("pri_raw2", 1, 1, 1, 0, 0);
        mcop(1, 1, 3, 1); cyc("pri_go",   1, 0, 0, 1, 2);

        // Reload of r4 while it is decrementing from 1 keeps it at LOAD_LAT.
        do_reset();
        load(4);        cyc("rl_load1", 1, 0, 0, 0, 0);
        load(4);        cyc("rl_load2", 1, 0, 0, 0, 0);
        rd(4);          cyc("rl_stall", 1, 1, 1, 0, 0);
        rd(4);          cyc("rl_go",    1, 0, 0, 1, 1);

        // Flush during a RAW stall clears it while counters keep draining.
        do_reset();
        load(3);        cyc("fl_load",  1, 0, 0, 0, 0);
        rd(3); hz.flush = 1'b1;
                        cyc("fl_flush", 1, 0, 0, 1, 0);
        rd(3);          cyc("fl_after", 1, 0, 0, 1, 0);

        // Reset mid-operation discards pending r5.
        do_reset();
        mcop(0, 0, 5, 4); cyc("rm_mc",   1, 0, 0, 0, 0);
        nop();            cyc("rm_idle", 1, 0, 0, 0, 0);
        rst = 1'b1;
        nop();            cyc("rm_rst",  1, 0, 0, 0, 0);
        rst = 1'b0;
        rd(5);            cyc("rm_read", 1, 0, 0, 1, 0);

        // 21 stalled cycles on a 4-bit counter saturate at 15.
        do_reset();
        mcop(0, 0, 5, 7); cyc("sat_seed", 1, 0, 0, 1, 0);
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 7; i++) begin
                mcop(5, 1, 5, 7); cyc("sat_stall", 1, 1, 1, 0, 0);
            end
            mcop(5, 1, 5, 7);
            cyc("sat_issue", 1, 0, 0, 1, ((k + 1) * 7 > 15) ? 15 : (k + 1) * 7);
        end
        nop();            cyc("sat_hold", 1, 0, 0, 1, 15);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the single-issue hazard detector in the decode stage.
- Replaces fixed ID/EX, EX/MEM and MEM/WB comparisons with a per-register countdown scoreboard.
- Adds load-use and variable-latency multi-cycle RAW stalls, WAW ordering stalls, multi-cycle unit structural stalls, stall-cause reporting and a saturating stall counter.
- Sits in decode and drives the PC write enable, the IF/ID write enable and the ID/EX bubble insert.

Parameters:
NUM_REGS, 8, architectural registers tracked
REG_W, 3, register index width (clog2 NUM_REGS)
LAT_W, 3, width of latency values and countdown counters
ALU_LAT, 0, stall cycles an ALU result imposes on a dependent op (0 means full bypass)
LOAD_LAT, 1, stall cycles a load result imposes on a dependent op
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_valid  in  1  IF/ID holds a valid instruction
id_rs  in  REG_W  source 1 index
id_rs_used  in  1  source 1 is read (low for J/JAL)
id_rt  in  REG_W  source 2 index
id_rt_used  in  1  source 2 is read
id_dst  in  REG_W  destination index
id_dst_we  in  1  instruction writes id_dst
id_is_load  in  1  load instruction
id_is_mc  in  1  multi-cycle unit instruction
id_mc_lat  in  LAT_W  latency of this multi-cycle op, 1..2^LAT_W-1
flush  in  1  squash the instruction in IF/ID this cycle
stall  out  1  hold the front end
pc_we  out  1  ~stall
ifid_we  out  1  ~stall
idex_bubble  out  1  insert NOP into ID/EX
stall_cause  out  2  0 none, 1 RAW, 2 structural, 3 WAW
stall_count  out  CNT_W  saturating count of stalled cycles

Behaviour:
Interface:
- Single clock clk.
- Reset rst is synchronous and active-high.

State:
- cnt[r] (LAT_W bits, one per register).
- mc_busy (LAT_W bits).
- stall_count.

Reset:
- All cnt, mc_busy and stall_count are 0.
- Therefore stall=0, pc_we=1, ifid_we=1, idex_bubble=0, stall_cause=0.
- A reset mid-operation discards all pending entries.

Latency selection:
- lat = id_mc_lat if id_is_mc; else LOAD_LAT if id_is_load; else ALU_LAT.

Hazards (combinational from current state, gated by id_valid & ~flush):
- raw = (id_rs_used & cnt[id_rs]!=0) | (id_rt_used & cnt[id_rt]!=0)
- strc = id_is_mc & mc_busy!=0
- waw = id_dst_we & (cnt[id_dst] > lat)
- stall = raw | strc | waw.
- stall_cause priority: RAW > structural > WAW.

Output rules:
- idex_bubble = stall | flush | ~id_valid.
- issue = id_valid & ~flush & ~stall.
- flush forces stall=0 and cause=0.

Sequential update, every cycle:
- Each nonzero cnt[r] decrements by 1.
- Nonzero mc_busy decrements by 1.
- On issue with id_dst_we: cnt[id_dst] <= lat. The load overrides the decrement on that register in the same cycle.
- On issue with id_is_mc: mc_busy <= id_mc_lat.
- Counters never underflow. Zero stays zero.

Latency semantics:
- A dependent op issued directly behind a producer with latency L stalls exactly L cycles.
- With LOAD_LAT=1, a load-use sequence gives one bubble.

Stall counter:
- stall_count increments when stall=1.
- It holds at 2^CNT_W-1.

Other rules:
- No register is hardwired. All NUM_REGS are tracked.
- A source equal to the destination of the same instruction is not a self-hazard, since only state from older ops is checked.

Decomposition:
- Shared package hazard_pkg holds stall_cause encodings (CAUSE_NONE, CAUSE_RAW, CAUSE_STRUCT, CAUSE_WAW) and default latency constants.
- One natural sub-module, sb_counter: a LAT_W down-counter with synchronous load and reset. It is instantiated NUM_REGS times plus once for mc_busy.

Test Plan:
- Reset: assert rst for 2 cycles with id_valid=1 -> stall=0, pc_we=1, stall_count=0, all cnt=0.
- Load-use: issue load to r3, next cycle add reading r3 -> exactly 1 cycle with stall=1 and cause=1, add issues on the 2nd cycle, stall_count=1.
- Multi-cycle RAW: mc op to r5 with id_mc_lat=4, next op reads r5 -> 4 stall cycles with cause=1. A concurrent ALU op reading r2 in a separate run -> no stall.
- Structural and WAW: mc op with lat=5, then mc op -> cause=2 for 5 cycles. In a separate run, mc op with lat=5 to r1, then ALU op writing r1 -> cause=3 while cnt[r1]>0, then it issues.
- Simultaneous events: issue load to r4 while cnt[r4]=1 is decrementing -> cnt[r4]=LOAD_LAT next cycle. Flush during a RAW stall -> stall=0, idex_bubble=1, counters still decrement.
- Reset mid-op and saturation: rst while cnt[r5]=3 -> a following reader of r5 issues with no stall. Hold a stall for 2^CNT_W+5 cycles (CNT_W=4 build) -> stall_count stays at 15.
